inv_expand_key_128: RTL
=======================

// Module: inv_expand_key_128
// PURPOSE
//  Iterative AES-128 inverse key schedule for the decrypt path. Takes the round-10 key and emits
//  round keys 10,9,...,0 one at a time over a valid/ready stream to the inverse-cipher rounds.
//  Each step undoes one forward expansion step, using the forward S-box on the recovered word w[i+3].
//  Sits beside the forward key expander; it shares that expander's S-box word primitive and rcon table.
// PARAMETERS
//  RK_ROUND_W   4   width of rk_round output; fixed for AES-128 (11 keys, rounds 10..0)
// PORTS
//  clk        in   1    single clock, all state on posedge
//  rst_n      in   1    reset, asynchronous, active-low
//  start      in   1    begin schedule; sampled only in IDLE
//  key_in     in   128  round-10 key {w0,w1,w2,w3}, w0 = [127:96]; sampled with start
//  busy       out  1    high from cycle after accepted start until done pulse
//  rk_valid   out  1    rk_out/rk_round hold a round key
//  rk_ready   in   1    consumer accepts the key when rk_valid & rk_ready
//  rk_out     out  128  current round key
//  rk_round   out  4    round index of rk_out (10 down to 0)
//  done       out  1    one-cycle pulse after round-0 key accepted
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, rk_valid, done, rk_out, rk_round = 0; key/rcon regs 0.
//    Reset mid-schedule aborts immediately; no partial key is re-emitted after release.
//  - FSM: IDLE, EMIT, SUB, DONE. Any unused encoding -> IDLE.
//  - IDLE: start=1 -> key_r<=key_in, round_r<=10, rcon_r<=8'h36, goto EMIT. start=0 -> stay.
//  - EMIT: rk_valid=1, rk_out=key_r, rk_round=round_r; both stable while rk_ready=0.
//      handshake & round_r==0 -> DONE; handshake & round_r!=0 -> SUB, and present
//      RotWord(key_r[31:0]^key_r[63:32]) (rotate left 8) to the S-box sub-module the same cycle.
//  - SUB (1 cycle, rk_valid=0): s = registered SubWord output. With key words a0..a3:
//      p3=a3^a2, p2=a2^a1, p1=a1^a0, p0=a0^s^{rcon_r,24'h0}; key_r<={p0,p1,p2,p3};
//      round_r<=round_r-1; rcon_r<= (rcon_r==8'h1b) ? 8'h80 : rcon_r>>1; goto EMIT.
//  - rcon sequence used per step: 36,1b,80,40,20,10,08,04,02,01 (round 10 -> round 1).
//  - DONE: done=1 for exactly one cycle, busy=0 from next cycle, goto IDLE.
//  - busy=1 in EMIT and SUB; start while busy is ignored (no restart, no queue).
//  - Latency with rk_ready held 1: start accepted at cycle 0; keys at cycles 1,3,...,21; done at 22.
//  - rk_ready asserted without rk_valid has no effect. rk_out holds its last value outside EMIT.
//  - All XOR arithmetic is bitwise, no carries. round_r never decrements below 0.
// STRUCTURE
//  - Shared package aes_key_pkg: RCON_LAST=8'h36, RCON_WRAP=8'h1b, RCON_AFTER_WRAP=8'h80,
//    NUM_ROUND_KEYS=11, FSM state enum type, rot_word() function.
//  - One sub-module: sub_word_reg -- 4 forward S-box bytes, 32-bit in/out, output registered on clk,
//    no reset (data path). It is the same S-box word primitive used by the forward expander.
//  - Top holds FSM, key_r, round_r, rcon_r and the combine XOR network.
// TESTING
//  - FIPS-197 A.1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> round 10 = key_in,
//    round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605,
//    round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done at cycle 22.
//  - Backpressure: rk_ready random 30% duty -> same 11 keys in order; rk_out/rk_round stable while stalled.
//  - start pulsed again during round 5 with different key_in -> ignored; sequence completes unchanged.
//  - rst_n low during SUB of round 4 -> outputs 0 asynchronously; new start -> full schedule restarts at 10.
//  - Round-trip: random 128-bit keys through forward expander, feed its round-10 output -> round 0 equals
//    the original key; 1000 iterations, plus all-zero and all-ones keys.
//  - Back-to-back: start asserted on the cycle after done -> accepted; busy rises the next cycle.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: rcon constants, inverse
// schedule FSM states and the RotWord helper.
package aes_key_pkg;

    localparam logic [7:0] RCON_LAST       = 8'h36;
    localparam logic [7:0] RCON_WRAP       = 8'h1b;
    localparam logic [7:0] RCON_AFTER_WRAP = 8'h80;
    localparam int         NUM_ROUND_KEYS  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } ikey_state_t;

    // Cyclic byte rotate left: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word_reg.sv
// SubWord primitive: four forward AES S-boxes on a 32-bit word, registered
// output. Pure data path, so it carries no reset. The S-box is computed as
// the GF(2^8) multiplicative inverse followed by the affine transform.
module sub_word_reg (
    input  logic        clk,
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = '0;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^254 (maps 0 to 0), then the forward affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [3:0][7:0] sub_c;

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign sub_c[g] = sbox(word_in[8*g +: 8]);
    end

    // Capture every cycle; the consumer knows when the result is meaningful
    always_ff @(posedge clk) begin
        word_out <= sub_c;
    end

endmodule

// File: rtl/inv_expand_key_128.sv
// Iterative AES-128 inverse key schedule. Starting from the round-10 key,
// each SUB step undoes one forward expansion step and the resulting key is
// offered on a valid/ready stream, rounds 10 down to 0.
module inv_expand_key_128
    import aes_key_pkg::*;
#(
    parameter int RK_ROUND_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [127:0]          key_in,
    output logic                  busy,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [127:0]          rk_out,
    output logic [RK_ROUND_W-1:0] rk_round,
    output logic                  done
);

    ikey_state_t           state;
    logic [127:0]          key_r;
    logic [RK_ROUND_W-1:0] round_r;
    logic [7:0]            rcon_r;

    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  sub_in, s_word;
    logic [127:0] next_key;
    logic [7:0]   next_rcon;

    // Recovered w[i+3] = a3^a2 feeds the S-box; key_r is stable across the
    // accepting EMIT edge, so the registered SubWord is ready during SUB.
    assign {a0, a1, a2, a3} = key_r;
    assign sub_in           = rot_word(a3 ^ a2);

    sub_word_reg u_sub_word (
        .clk      (clk),
        .word_in  (sub_in),
        .word_out (s_word)
    );

    assign next_key  = {a0 ^ s_word ^ {rcon_r, 24'h0}, a1 ^ a0, a2 ^ a1, a3 ^ a2};
    // rcon walks backwards: 36,1b, then 80 down to 01
    assign next_rcon = (rcon_r == RCON_WRAP) ? RCON_AFTER_WRAP : (rcon_r >> 1);

    assign rk_out   = key_r;
    assign rk_round = round_r;

    // Schedule FSM with registered busy/valid/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            key_r    <= '0;
            round_r  <= '0;
            rcon_r   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_r    <= key_in;
                        round_r  <= RK_ROUND_W'(NUM_ROUND_KEYS - 1);
                        rcon_r   <= RCON_LAST;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (round_r == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    key_r    <= next_key;
                    round_r  <= round_r - RK_ROUND_W'(1);
                    rcon_r   <= next_rcon;
                    rk_valid <= 1'b1;
                    state    <= ST_EMIT;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    rk_valid <= 1'b0;
                    done     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
